// File: rtl/tamagotchi_pkg.sv
// Shared event codes, scheduler state encoding and pending-bit indices
// used by the event scheduler and the pet core.
package tamagotchi_pkg;

    localparam int NUM_EVT = 6;

    localparam int PEND_TEST     = 0;
    localparam int PEND_FEED     = 1;
    localparam int PEND_HEAL     = 2;
    localparam int PEND_CHANGE   = 3;
    localparam int PEND_DAYNIGHT = 4;
    localparam int PEND_OBJECT   = 5;

    typedef enum logic [2:0] {
        EVT_NONE     = 3'd0,
        EVT_TEST     = 3'd1,
        EVT_FEED     = 3'd2,
        EVT_HEAL     = 3'd3,
        EVT_CHANGE   = 3'd4,
        EVT_DAYNIGHT = 3'd5,
        EVT_OBJECT   = 3'd6
    } evt_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_COOL  = 2'd2
    } sched_state_e;

    // Isolates the lowest set bit, which is the highest-priority request.
    function automatic logic [NUM_EVT-1:0] lowest_set(input logic [NUM_EVT-1:0] req);
        return req & (~req + NUM_EVT'(1));
    endfunction

    // Pending index i maps to event code i+1.
    function automatic evt_code_e code_of(input logic [NUM_EVT-1:0] onehot);
        evt_code_e code;
        code = EVT_NONE;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (onehot[i]) begin
                code = evt_code_e'(3'(i + 1));
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Single-input edge detector: rising edge always, falling edge optional.
// Pulses are suppressed until the shared arm flag is set.
module edge_detect #(
    parameter bit FALL_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic din,
    output logic pulse
);

    logic prev_q;
    logic prev_d;
    logic rise;
    logic fall;

    always_comb begin
        prev_d = din;
        rise   = din & ~prev_q;
        fall   = ~din & prev_q;
        pulse  = arm & (rise | (FALL_EN & fall));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/event_scheduler.sv
// Turns button/sensor edges into a single stream of prioritised events,
// offered one at a time on a valid/ready port with a cooldown between events.
module event_scheduler
    import tamagotchi_pkg::*;
#(
    parameter int COOLDOWN = 50000,
    parameter int TIMEOUT  = 500000
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       feeding,
    input  logic       healing,
    input  logic       change,
    input  logic       test_sig,
    input  logic       light,
    input  logic       objectUltra,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic       evt_arg,
    output logic [5:0] pending,
    output logic       overrun,
    output logic       timeout,
    output logic [1:0] dbg_state
);

    // Handshake: evt_valid is high for the whole ISSUE state with evt_code/evt_arg
    // stable; an event is accepted in any cycle where evt_valid and evt_ready are
    // both high, and evt_valid never drops without acceptance except on timeout.

    localparam int CNT_MAX = (COOLDOWN > TIMEOUT) ? COOLDOWN : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CD_LOAD = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
    localparam logic [CW-1:0] TO_LOAD = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    sched_state_e         state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_EVT-1:0]   pending_q, pending_d;
    evt_code_e            code_q, code_d;
    logic                 arg_q, arg_d;
    logic                 light_lvl_q, light_lvl_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic                 armed_q, armed_d;
    logic [NUM_EVT-1:0]   evt_pulse;
    logic [NUM_EVT-1:0]   grant;

    edge_detect u_test (
        .clk(clk), .rst(Rst), .arm(armed_q), .din(test_sig), .pulse(evt_pulse[PEND_TEST])
    );
    edge_detect u_feed (
        .clk(clk), .rst(Rst), .arm(armed_q), .din(feeding), .pulse(evt_pulse[PEND_FEED])
    );
    edge_detect u_heal (
        .clk(clk), .rst(Rst), .arm(armed_q), .din(healing), .pulse(evt_pulse[PEND_HEAL])
    );
    edge_detect u_change (
        .clk(clk), .rst(Rst), .arm(armed_q), .din(change), .pulse(evt_pulse[PEND_CHANGE])
    );
    edge_detect #(.FALL_EN(1'b1)) u_light (
        .clk(clk), .rst(Rst), .arm(armed_q), .din(light), .pulse(evt_pulse[PEND_DAYNIGHT])
    );
    edge_detect u_object (
        .clk(clk), .rst(Rst), .arm(armed_q), .din(objectUltra), .pulse(evt_pulse[PEND_OBJECT])
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        arg_d       = arg_q;
        timeout_d   = timeout_q;
        grant       = '0;
        armed_d     = 1'b1;
        light_lvl_d = evt_pulse[PEND_DAYNIGHT] ? light : light_lvl_q;

        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    grant   = lowest_set(pending_q);
                    code_d  = code_of(grant);
                    arg_d   = grant[PEND_DAYNIGHT] & light_lvl_q;
                    cnt_d   = TO_LOAD;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Acceptance wins over expiry in the last allowed cycle.
                if (evt_ready || (cnt_q == '0)) begin
                    if (!evt_ready) begin
                        timeout_d = 1'b1;
                    end
                    if (COOLDOWN == 0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_COOL;
                        cnt_d   = CD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_COOL: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new edge on the bit granted this cycle re-arms it as a fresh event.
        pending_d = (pending_q & ~grant) | evt_pulse;
        overrun_d = overrun_q | (|(evt_pulse & pending_q & ~grant));
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pending_q   <= '0;
            code_q      <= EVT_NONE;
            arg_q       <= 1'b0;
            light_lvl_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            code_q      <= code_d;
            arg_q       <= arg_d;
            light_lvl_q <= light_lvl_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        evt_valid = (state_q == ST_ISSUE);
        evt_code  = evt_valid ? code_q : EVT_NONE;
        evt_arg   = evt_valid & arg_q;
        pending   = pending_q;
        overrun   = overrun_q;
        timeout   = timeout_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_event_scheduler.sv
// Directed bench for event_scheduler with COOLDOWN=4, TIMEOUT=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_event_scheduler;

    localparam int COOLDOWN = 4;
    localparam int TIMEOUT  = 8;

    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic       feeding, healing, change, test_sig, light, objectUltra;
    logic       evt_ready;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_arg;
    logic [5:0] pending;
    logic       overrun;
    logic       timeout;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    event_scheduler #(.COOLDOWN(COOLDOWN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .Rst(Rst),
        .feeding(feeding), .healing(healing), .change(change),
        .test_sig(test_sig), .light(light), .objectUltra(objectUltra),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_arg(evt_arg),
        .pending(pending), .overrun(overrun), .timeout(timeout),
        .dbg_state(dbg_state)
    );

    task automatic clear_inputs();
        feeding = 0; healing = 0; change = 0; test_sig = 0;
        light = 0; objectUltra = 0; evt_ready = 1;
    endtask

    // Leaves the bench at a falling edge with the detectors already armed.
    task automatic do_reset();
        clear_inputs();
        Rst = 1;
        repeat (2) @(negedge clk);
        Rst = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int nvalid;
        logic [5:0] pend_seen;
        clear_inputs();
        feeding = 1; light = 1; healing = 1;
        Rst = 1;
        #1;
        total++;
        if ({evt_valid, evt_code, evt_arg, pending, overrun, timeout, dbg_state} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {evt_valid, evt_code, evt_arg, pending, overrun, timeout, dbg_state});
        end
        repeat (3) @(negedge clk);
        total++;
        if ({evt_valid, evt_code, evt_arg, pending, overrun, timeout, dbg_state} !== 15'd0) begin
            bad++;
            $display("FAIL reset_hold: got %h expected 0",
                     {evt_valid, evt_code, evt_arg, pending, overrun, timeout, dbg_state});
        end
        Rst = 0;
        nvalid = 0;
        pend_seen = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (evt_valid) nvalid++;
            pend_seen |= pending;
        end
        total++;
        if (nvalid !== 0) begin
            bad++;
            $display("FAIL held_levels_no_event: got %0d valid cycles expected 0", nvalid);
        end
        total++;
        if (pend_seen !== 6'd0) begin
            bad++;
            $display("FAIL held_levels_no_pending: got %b expected 000000", pend_seen);
        end
    endtask

    task automatic test_single_feed();
        int early;
        do_reset();
        early = 0;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            feeding = (k == 0 || k == 3 || k == 7);
            if (k == 1) begin
                total++;
                if ({evt_valid, pending} !== 7'b0_000010) begin
                    bad++;
                    $display("FAIL feed_pending: got valid=%b pending=%b expected valid=0 pending=000010",
                             evt_valid, pending);
                end
            end
            if (k == 2) begin
                total++;
                if ({evt_valid, evt_code, evt_arg, pending} !== {1'b1, 3'd2, 1'b0, 6'd0}) begin
                    bad++;
                    $display("FAIL feed_issue: got v=%b c=%0d a=%b p=%b expected v=1 c=2 a=0 p=000000",
                             evt_valid, evt_code, evt_arg, pending);
                end
            end
            if (k == 3) begin
                total++;
                if ({evt_valid, evt_code, evt_arg, dbg_state} !== {1'b0, 3'd0, 1'b0, 2'd2}) begin
                    bad++;
                    $display("FAIL feed_cool: got v=%b c=%0d a=%b st=%0d expected v=0 c=0 a=0 st=2",
                             evt_valid, evt_code, evt_arg, dbg_state);
                end
            end
            if (k >= 4 && k <= 7 && evt_valid) early++;
            if (k == 8) begin
                total++;
                if ({evt_valid, evt_code, pending, overrun} !== {1'b1, 3'd2, 6'b000010, 1'b0}) begin
                    bad++;
                    $display("FAIL grant_edge_same_cycle: got v=%b c=%0d p=%b ovr=%b expected v=1 c=2 p=000010 ovr=0",
                             evt_valid, evt_code, pending, overrun);
                end
            end
            if (k == 14) begin
                total++;
                if ({evt_valid, evt_code, pending} !== {1'b1, 3'd2, 6'd0}) begin
                    bad++;
                    $display("FAIL feed_third: got v=%b c=%0d p=%b expected v=1 c=2 p=000000",
                             evt_valid, evt_code, pending);
                end
            end
        end
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL cooldown_gap: got %0d valid cycles in cooldown expected 0", early);
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL feed_no_overrun: got %b expected 0", overrun);
        end
    endtask

    // Drives one simultaneous burst at k=0 and checks codes and issue cycles.
    task automatic run_burst(input string name, input logic [5:0] burst,
                             input logic [5:0] exp_pend1,
                             input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                             input int nexp);
        logic [2:0] exp_q[$];
        int         cyc_q[$];
        logic [2:0] got_q[$];
        int         got_cyc[$];
        int         idle_dirty;
        exp_q = '{c0, c1, c2};
        while (exp_q.size() > nexp) void'(exp_q.pop_back());
        for (int i = 0; i < nexp; i++) cyc_q.push_back(2 + 6 * i);
        do_reset();
        idle_dirty = 0;
        for (int k = 0; k < 6 * nexp + 4; k++) begin
            @(negedge clk);
            {objectUltra, light, change, healing, feeding, test_sig} = (k == 0) ? burst : 6'd0;
            if (k == 1) begin
                total++;
                if (pending !== exp_pend1) begin
                    bad++;
                    $display("FAIL %s_pending: got %b expected %b", name, pending, exp_pend1);
                end
            end
            if (evt_valid) begin
                got_q.push_back(evt_code);
                got_cyc.push_back(k);
            end else if (evt_code !== 3'd0 || evt_arg !== 1'b0) begin
                idle_dirty++;
            end
        end
        total++;
        if (got_q.size() !== nexp) begin
            bad++;
            $display("FAIL %s_count: got %0d events expected %0d", name, got_q.size(), nexp);
        end else begin
            for (int i = 0; i < nexp; i++) begin
                total++;
                if (got_q[i] !== exp_q[i] || got_cyc[i] !== cyc_q[i]) begin
                    bad++;
                    $display("FAIL %s_event%0d: got code=%0d at %0d expected code=%0d at %0d",
                             name, i, got_q[i], got_cyc[i], exp_q[i], cyc_q[i]);
                end
            end
        end
        total++;
        if (idle_dirty !== 0 || pending !== 6'd0) begin
            bad++;
            $display("FAIL %s_end: got idle_dirty=%0d pending=%b expected 0 and 000000",
                     name, idle_dirty, pending);
        end
    endtask

    task automatic test_simultaneous();
        // test_sig, feeding, healing together
        run_burst("simul", 6'b000111, 6'b000111, 3'd1, 3'd2, 3'd3, 3);
    endtask

    task automatic test_priority_high();
        // change and objectUltra together
        run_burst("prio", 6'b101000, 6'b101000, 3'd4, 3'd6, 3'd0, 2);
    endtask

    task automatic test_timeout();
        int nv;
        int first;
        int codes_bad;
        do_reset();
        evt_ready = 0;
        nv = 0; first = -1; codes_bad = 0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            change = (k == 0);
            if (evt_valid) begin
                nv++;
                if (first < 0) first = k;
                if (evt_code !== 3'd4) codes_bad++;
            end
            if (k == 9) begin
                total++;
                if ({evt_valid, timeout} !== 2'b10) begin
                    bad++;
                    $display("FAIL timeout_last_cycle: got v=%b to=%b expected v=1 to=0", evt_valid, timeout);
                end
            end
            if (k == 10) begin
                total++;
                if ({evt_valid, timeout, dbg_state} !== {1'b0, 1'b1, 2'd2}) begin
                    bad++;
                    $display("FAIL timeout_drop: got v=%b to=%b st=%0d expected v=0 to=1 st=2",
                             evt_valid, timeout, dbg_state);
                end
            end
        end
        total++;
        if (nv !== 8 || first !== 2 || codes_bad !== 0) begin
            bad++;
            $display("FAIL timeout_window: got %0d cycles from %0d bad_codes=%0d expected 8 from 2 bad_codes=0",
                     nv, first, codes_bad);
        end
        total++;
        if ({timeout, pending} !== {1'b1, 6'd0}) begin
            bad++;
            $display("FAIL timeout_sticky: got to=%b p=%b expected to=1 p=000000", timeout, pending);
        end
        Rst = 1;
        #1;
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_clears_timeout: got %b expected 0", timeout);
        end
    endtask

    task automatic test_overrun();
        int acc_cyc[$];
        logic [2:0] acc_code[$];
        do_reset();
        evt_ready = 0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            feeding   = (k == 0 || k == 2 || k == 4);
            evt_ready = (k >= 6);
            if (evt_valid && evt_ready) begin
                acc_cyc.push_back(k);
                acc_code.push_back(evt_code);
            end
            if (k == 3) begin
                total++;
                if ({pending, overrun} !== {6'b000010, 1'b0}) begin
                    bad++;
                    $display("FAIL ovr_first_edge: got p=%b ovr=%b expected p=000010 ovr=0", pending, overrun);
                end
            end
            if (k == 5) begin
                total++;
                if ({pending, overrun} !== {6'b000010, 1'b1}) begin
                    bad++;
                    $display("FAIL ovr_merge: got p=%b ovr=%b expected p=000010 ovr=1", pending, overrun);
                end
            end
        end
        total++;
        if (acc_cyc.size() !== 2) begin
            bad++;
            $display("FAIL ovr_count: got %0d accepted expected 2", acc_cyc.size());
        end else begin
            total++;
            if (acc_cyc[0] !== 6 || acc_cyc[1] !== 12 || acc_code[0] !== 3'd2 || acc_code[1] !== 3'd2) begin
                bad++;
                $display("FAIL ovr_events: got c%0d@%0d c%0d@%0d expected c2@6 c2@12",
                         acc_code[0], acc_cyc[0], acc_code[1], acc_cyc[1]);
            end
        end
        total++;
        if ({overrun, timeout, pending} !== {1'b1, 1'b0, 6'd0}) begin
            bad++;
            $display("FAIL ovr_end: got ovr=%b to=%b p=%b expected ovr=1 to=0 p=000000",
                     overrun, timeout, pending);
        end
    endtask

    task automatic test_daynight();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            light = (k < 10);
            if (k == 1) begin
                total++;
                if (pending !== 6'b010000) begin
                    bad++;
                    $display("FAIL dn_pending: got %b expected 010000", pending);
                end
            end
            if (k == 2 || k == 12) begin
                total++;
                if ({evt_valid, evt_code, evt_arg} !== {1'b1, 3'd5, (k == 2)}) begin
                    bad++;
                    $display("FAIL dn_event_k%0d: got v=%b c=%0d a=%b expected v=1 c=5 a=%b",
                             k, evt_valid, evt_code, evt_arg, (k == 2));
                end
            end
            if (k == 3) begin
                total++;
                if ({evt_valid, evt_code, evt_arg} !== 5'd0) begin
                    bad++;
                    $display("FAIL dn_idle_zero: got v=%b c=%0d a=%b expected all 0",
                             evt_valid, evt_code, evt_arg);
                end
            end
        end
    endtask

    task automatic test_reset_mid_issue();
        int nvalid;
        logic [5:0] pend_seen;
        do_reset();
        evt_ready = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            healing  = 1;
            test_sig = (k == 3);
            if (k == 2) begin
                total++;
                if ({evt_valid, evt_code} !== {1'b1, 3'd3}) begin
                    bad++;
                    $display("FAIL mid_issue_heal: got v=%b c=%0d expected v=1 c=3", evt_valid, evt_code);
                end
            end
            if (k == 4) begin
                total++;
                if ({evt_valid, pending} !== {1'b1, 6'b000001}) begin
                    bad++;
                    $display("FAIL mid_issue_pending: got v=%b p=%b expected v=1 p=000001", evt_valid, pending);
                end
            end
        end
        @(negedge clk);
        test_sig = 0;
        Rst = 1;
        #1;
        total++;
        if ({evt_valid, evt_code, evt_arg, pending, overrun, timeout, dbg_state} !== 15'd0) begin
            bad++;
            $display("FAIL async_reset_clear: got %h expected 0",
                     {evt_valid, evt_code, evt_arg, pending, overrun, timeout, dbg_state});
        end
        @(negedge clk);
        Rst = 0;
        evt_ready = 1;
        nvalid = 0;
        pend_seen = '0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (evt_valid) nvalid++;
            pend_seen |= pending;
        end
        total++;
        if (nvalid !== 0 || pend_seen !== 6'd0) begin
            bad++;
            $display("FAIL no_reissue: got %0d valid cycles pending=%b expected 0 and 000000",
                     nvalid, pend_seen);
        end
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            healing = (j != 0);
            if (j == 3) begin
                total++;
                if ({evt_valid, evt_code, evt_arg} !== {1'b1, 3'd3, 1'b0}) begin
                    bad++;
                    $display("FAIL heal_after_new_edge: got v=%b c=%0d a=%b expected v=1 c=3 a=0",
                             evt_valid, evt_code, evt_arg);
                end
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_feed();
        test_simultaneous();
        test_priority_high();
        test_timeout();
        test_overrun();
        test_daynight();
        test_reset_mid_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/event_scheduler.md
EVENT_SCHEDULER -- requirements
Module: event_scheduler

Interface
REQ-001 Parameter COOLDOWN, default 50000, idle cycles enforced after each accepted event (0 = none).
REQ-002 Parameter TIMEOUT, default 500000, max cycles evt_valid waits for evt_ready (>=1).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 feeding, healing, change  input  1 each  debounced button levels, clk-synchronous.
REQ-006 test_sig, light, objectUltra  input  1 each  held test, day/night and object-detect levels, clk-synchronous.
REQ-007 evt_ready  input  1  pet core accepts current event.
REQ-008 evt_valid  output  1  event offered.
REQ-009 evt_code  output  3  1=TEST 2=FEED 3=HEAL 4=CHANGE 5=DAYNIGHT 6=OBJECT, 0 when idle.
REQ-010 evt_arg  output  1  light level captured at the DAYNIGHT edge; 0 for other codes.
REQ-011 pending  output  6  pending bits, [0]=TEST ... [5]=OBJECT.
REQ-012 overrun  output  1  sticky: an edge arrived while its pending bit was already set.
REQ-013 timeout  output  1  sticky: an offered event was dropped after TIMEOUT cycles.

Function
REQ-014 Edge detect: rising edge of feeding/healing/change/test_sig/objectUltra, and either edge of light, each set the matching pending bit one cycle after the edge appears.
REQ-015 First cycle after reset release arms the detectors only: previous-value registers load the inputs and no event is generated, so levels held through reset produce no event.
REQ-016 FSM states IDLE, ISSUE, COOL; reset state IDLE.
REQ-017 IDLE: if any pending bit is set, grant the lowest-index set bit (fixed priority TEST>FEED>HEAL>CHANGE>DAYNIGHT>OBJECT), latch its code/arg, clear that bit, go to ISSUE; else stay.
REQ-018 ISSUE: evt_valid=1, evt_code/evt_arg held stable; on evt_ready=1 go to COOL (or IDLE if COOLDOWN=0).
REQ-019 ISSUE: if evt_ready not seen within TIMEOUT cycles of entry, set timeout, drop the event, go to COOL (or IDLE if COOLDOWN=0).
REQ-020 COOL: counter loads COOLDOWN-1 on entry, decrements each cycle, returns to IDLE at 0; evt_valid=0.
REQ-021 Latency: edge at cycle n -> pending at n+1 -> evt_valid at n+2 when FSM is in IDLE with no higher-priority bit set.
REQ-022 Edge on the bit being granted in the same cycle: bit stays set (new event), no overrun.
REQ-023 Edge on an already-set pending bit: bit stays set, overrun set; the event is merged.
REQ-024 Pending bits keep accumulating in ISSUE and COOL; none lost except per REQ-023.
REQ-025 evt_code=0 and evt_arg=0 whenever evt_valid=0.
REQ-026 Counters sized $clog2(max(COOLDOWN,TIMEOUT)+1); no wrap-around permitted.

Reset
REQ-027 Rst asserted at any time, including mid-ISSUE or mid-COOL: FSM to IDLE, evt_valid/evt_code/evt_arg/pending/overrun/timeout to 0, counters to 0, detector-armed flag cleared, immediately and asynchronously.
REQ-028 An in-flight event is discarded on reset; no event reissued after release.

Structure
REQ-029 Event codes, state encoding and pending-bit indices in shared package tamagotchi_pkg, reused by the pet core.
REQ-030 One sub-module, edge_detect (one per input: rise, optional fall, arm), instantiated six times; arbiter, FSM and counters in the top module.

Verification (COOLDOWN=4, TIMEOUT=8)
REQ-031 feeding pulse at cycle 10, evt_ready tied 1 -> evt_valid=1, evt_code=2 at cycle 12 for one cycle; next grant no earlier than cycle 17.
REQ-032 feeding, healing, test_sig rise same cycle -> codes issued in order 1, 2, 3, each separated by COOLDOWN; pending ends 0.
REQ-033 evt_ready held 0 -> evt_valid high exactly 8 cycles, then drops, timeout=1, event not reissued.
REQ-034 Two feeding edges while FSM in ISSUE -> overrun=1, exactly one extra FEED issued.
REQ-035 light 0->1 then 1->0 -> two DAYNIGHT events, evt_arg 1 then 0.
REQ-036 Rst pulsed mid-ISSUE with healing held high -> all outputs 0; after release no HEAL event until a new rising edge.
